// File: rtl/axis_adc_ddr_calib_run.sv
// Longest-passing-run tracker for one IDELAY tap sweep.
// Scores arrive in ascending tap order; the best run is the strictly longest, so ties keep the lower tap.
module axis_adc_ddr_calib_run #(
    parameter int unsigned TAP_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 clr,
    input  logic                 score_en,
    input  logic                 pass,
    input  logic                 last,
    input  logic [TAP_WIDTH-1:0] tap,
    output logic [TAP_WIDTH-1:0] best_start,
    output logic [TAP_WIDTH:0]   best_len
);

    logic [TAP_WIDTH-1:0] cur_start_q, cur_start_d;
    logic [TAP_WIDTH:0]   cur_len_q, cur_len_d;
    logic [TAP_WIDTH-1:0] best_start_q, best_start_d;
    logic [TAP_WIDTH:0]   best_len_q, best_len_d;

    logic [TAP_WIDTH-1:0] ext_start;
    logic [TAP_WIDTH:0]   ext_len;
    logic [TAP_WIDTH-1:0] close_start;
    logic [TAP_WIDTH:0]   close_len;

    always_comb begin
        ext_len      = cur_len_q + 1'b1;
        ext_start    = (cur_len_q == '0) ? tap : cur_start_q;
        // A passing top tap still closes its run: no wrap-around to tap 0.
        close_len    = pass ? ext_len : cur_len_q;
        close_start  = pass ? ext_start : cur_start_q;

        cur_start_d  = cur_start_q;
        cur_len_d    = cur_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;

        if (clr) begin
            cur_start_d  = '0;
            cur_len_d    = '0;
            best_start_d = '0;
            best_len_d   = '0;
        end else if (score_en) begin
            if (!pass || last) begin
                cur_len_d = '0;
                if (close_len > best_len_q) begin
                    best_len_d   = close_len;
                    best_start_d = close_start;
                end
            end else begin
                cur_len_d   = ext_len;
                cur_start_d = ext_start;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
        end else begin
            cur_start_q  <= cur_start_d;
            cur_len_q    <= cur_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
        end
    end

    assign best_start = best_start_q;
    assign best_len   = best_len_q;

endmodule

// File: rtl/axis_adc_ddr_calib.sv
// DDR ADC input-delay calibration: sweeps each lane's IDELAY against a known pattern,
// then loads the centre of the longest passing window and reports it per lane.
module axis_adc_ddr_calib #(
    parameter int unsigned ADC_DATA_WIDTH = 7,
    parameter int unsigned TAP_WIDTH      = 5,
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned COMPARE_CYCLES = 256
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic                                cfg_start,
    input  logic [2*ADC_DATA_WIDTH-1:0]         cfg_pattern,
    input  logic [2*ADC_DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic                                s_axis_tvalid,
    output logic [ADC_DATA_WIDTH-1:0]           dly_ld,
    output logic [TAP_WIDTH-1:0]                dly_tap,
    output logic                                sts_busy,
    output logic                                sts_done,
    output logic [ADC_DATA_WIDTH-1:0]           sts_error,
    output logic [ADC_DATA_WIDTH*TAP_WIDTH-1:0] sts_taps
);

    localparam int unsigned LANE_W  = (ADC_DATA_WIDTH > 1) ? $clog2(ADC_DATA_WIDTH) : 1;
    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > COMPARE_CYCLES) ? SETTLE_CYCLES
                                                                       : COMPARE_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_SCORE  = 3'd4;
    localparam logic [2:0] S_CENTER = 3'd5;
    localparam logic [2:0] S_APPLY  = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    logic [2:0]                          state_q, state_d;
    logic [TAP_WIDTH-1:0]                tap_q, tap_d;
    logic [LANE_W-1:0]                   lane_q, lane_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic                                fail_q, fail_d;
    logic [TAP_WIDTH-1:0]                final_q, final_d;
    logic                                busy_q;
    logic                                done_q, done_d;
    logic [ADC_DATA_WIDTH-1:0]           error_q, error_d;
    logic [ADC_DATA_WIDTH*TAP_WIDTH-1:0] taps_q, taps_d;
    logic                                start_q;

    logic                                start_edge;
    logic                                run_clr;
    logic                                score_en;
    logic                                tap_last;
    logic [TAP_WIDTH-1:0]                best_start;
    logic [TAP_WIDTH:0]                  best_len;

    assign start_edge = cfg_start & ~start_q;
    assign tap_last   = (tap_q == {TAP_WIDTH{1'b1}});

    axis_adc_ddr_calib_run #(
        .TAP_WIDTH (TAP_WIDTH)
    ) u_run (
        .clk        (aclk),
        .resetn     (aresetn),
        .clr        (run_clr),
        .score_en   (score_en),
        .pass       (~fail_q),
        .last       (tap_last),
        .tap        (tap_q),
        .best_start (best_start),
        .best_len   (best_len)
    );

    always_comb begin
        state_d  = state_q;
        tap_d    = tap_q;
        lane_d   = lane_q;
        cnt_d    = cnt_q;
        fail_d   = fail_q;
        final_d  = final_q;
        done_d   = done_q;
        error_d  = error_q;
        taps_d   = taps_q;
        run_clr  = 1'b0;
        score_en = 1'b0;
        dly_ld   = '0;
        dly_tap  = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_edge) begin
                    state_d = S_LOAD;
                    lane_d  = '0;
                    tap_d   = '0;
                    done_d  = 1'b0;
                    error_d = '0;
                    taps_d  = '0;
                    run_clr = 1'b1;
                end
            end
            S_LOAD: begin
                dly_ld  = ADC_DATA_WIDTH'(1) << lane_q;
                dly_tap = tap_q;
                cnt_d   = '0;
                fail_d  = 1'b0;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                // Only qualified samples advance the window.
                if (s_axis_tvalid) begin
                    if (s_axis_tdata[2*lane_q +: 2] != cfg_pattern[2*lane_q +: 2]) begin
                        fail_d = 1'b1;
                    end
                    if (cnt_q == CNT_W'(COMPARE_CYCLES - 1)) begin
                        state_d = S_SCORE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_SCORE: begin
                score_en = 1'b1;
                if (tap_last) begin
                    state_d = S_CENTER;
                end else begin
                    tap_d   = tap_q + 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_CENTER: begin
                if (best_len == '0) begin
                    error_d[lane_q] = 1'b1;
                    final_d         = '0;
                end else begin
                    final_d = best_start + TAP_WIDTH'((best_len - 1'b1) >> 1);
                end
                taps_d[lane_q*TAP_WIDTH +: TAP_WIDTH] = final_d;
                state_d = S_APPLY;
            end
            S_APPLY: begin
                dly_ld  = ADC_DATA_WIDTH'(1) << lane_q;
                dly_tap = final_q;
                run_clr = 1'b1;
                if (lane_q == LANE_W'(ADC_DATA_WIDTH - 1)) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    lane_d  = lane_q + 1'b1;
                    tap_d   = '0;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
            tap_q   <= '0;
            lane_q  <= '0;
            cnt_q   <= '0;
            fail_q  <= 1'b0;
            final_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= '0;
            taps_q  <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            final_q <= final_d;
            busy_q  <= (state_d != S_IDLE) && (state_d != S_DONE);
            done_q  <= done_d;
            error_q <= error_d;
            taps_q  <= taps_d;
            start_q <= cfg_start;
        end
    end

    assign sts_busy  = busy_q;
    assign sts_done  = done_q;
    assign sts_error = error_q;
    assign sts_taps  = taps_q;

endmodule
